// File: rtl/md_unit.sv
// Radix-2 iterative multiply/divide unit holding the HI/LO pair.
// Define MDU_ACC_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_we,
   input  logic             hilo_sel,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dz_q, dz_d;

   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, dvs_q;
   logic               a_neg_q, b_neg_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] res;
   logic               accept, hilo_wr, is_div, last, op_ok;

   // Upper half accumulates the multiplicand, lower half shifts out multiplier bits.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {sum, p[WIDTH-1:1]};
   endfunction

   // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   d);
      logic [WIDTH:0] sh, diff;
      sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      diff = sh - {1'b0, d};
      if (sh >= {1'b0, d})
         return {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      else
         return {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
   endfunction

`ifdef MDU_ACC_EN
   logic [2*WIDTH-1:0] snap_q;
   assign op_ok = 1'b1;
   always_ff @(posedge clk) begin
      if (accept) snap_q <= {hi_q, lo_q};
   end
`else
   assign op_ok = ~op[2];
`endif

   always_comb begin : ctrl_decode
      hilo_wr = (state_q == S_IDLE) && hilo_we;
      accept  = (state_q == S_IDLE) && start && !hilo_we && op_ok;
      is_div  = !op_q[2] && op_q[1];
      last    = (cnt_q == CW'(WIDTH-1));
   end

   always_ff @(posedge clk or negedge rst) begin : state_reg
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (accept) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (last) state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operands enter the datapath as magnitudes; signs are reapplied in FIX.
   always_ff @(posedge clk) begin : datapath
      if (accept) begin
         op_q    <= op;
         a_q     <= a;
         a_neg_q <= op[0] & a[WIDTH-1];
         b_neg_q <= op[0] & b[WIDTH-1];
         dvs_q   <= (op[0] & b[WIDTH-1]) ? -b : b;
         prod_q  <= {{WIDTH{1'b0}}, (op[0] & a[WIDTH-1]) ? -a : a};
      end else if (state_q == S_RUN) begin
         prod_q  <= is_div ? div_step(prod_q, dvs_q) : mul_step(prod_q, dvs_q);
      end
   end

   always_comb begin : fix_stage
      logic [WIDTH-1:0]   q, r;
      logic [2*WIDTH-1:0] p;
      q = prod_q[WIDTH-1:0];
      r = prod_q[2*WIDTH-1:WIDTH];
      if (a_neg_q ^ b_neg_q) q = -q;
      if (a_neg_q) r = -r;
      p = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
`ifdef MDU_ACC_EN
      if (op_q[2]) p = op_q[1] ? (snap_q - p) : (snap_q + p);
`endif
      if (is_div)
         res = (dvs_q == '0) ? {a_q, {WIDTH{1'b1}}} : {r, q};
      else
         res = p;
   end

   always_comb begin : outputs
      hi_d   = hi_q;
      lo_d   = lo_q;
      dz_d   = dz_q;
      done_d = (state_q == S_FIX);
      if (state_q == S_FIX) begin
         hi_d = res[2*WIDTH-1:WIDTH];
         lo_d = res[WIDTH-1:0];
         if (is_div) dz_d = (dvs_q == '0);
      end else if (hilo_wr) begin
         if (hilo_sel) hi_d = a;
         else          lo_d = a;
      end
      busy = (state_q != S_IDLE);
      done = done_q;
      dz   = dz_q;
      hi   = hi_q;
      lo   = lo_q;
   end
endmodule
